// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter with a valid/ready word input and a framed bit stream output.
// The stream is zero-filled between words, so a downstream detector never sees stray 1s.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign accept   = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (accept) state_next = SHIFT;
            SHIFT: if (last_bit && !accept) state_next = IDLE;
        endcase
    end

    // Outputs decode only registered state, never din or din_valid.
    always_comb begin
        din_ready  = (state == IDLE) || last_bit;
        sout_valid = (state == SHIFT);
        busy       = (state == SHIFT);
        sout_last  = last_bit;
        sout       = 1'b0;
        if (state == SHIFT) begin
            sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= din;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            if (last_bit) begin
                shreg <= '0;
                cnt   <= '0;
            end else begin
                if (MSB_FIRST) begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end else begin
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
